// File: rtl/DH_pkg.sv
// Display-hardware package: VESA mode table, derived counter limits and the
// mode-switch FSM state type shared by the timing generator and its mode
// controller.
//   vga_mode_t    one mode: H/V active, front porch, sync, back porch, polarity
//   vga_lim_t     compare thresholds derived from one vga_mode_t
//   VGA_MODES     index 0 = 1024x768@60 (negative syncs), 1 = 800x600@60 (positive)
package DH_pkg;

   localparam int unsigned MODE_W    = 11;
   localparam int unsigned NUM_MODES = 2;
   localparam int unsigned FRAME_W   = 16;

   localparam logic MODE_1024X768 = 1'b0;
   localparam logic MODE_800X600  = 1'b1;

   typedef struct packed {
      logic [MODE_W-1:0] h_active;
      logic [MODE_W-1:0] h_fp;
      logic [MODE_W-1:0] h_sync;
      logic [MODE_W-1:0] h_bp;
      logic [MODE_W-1:0] v_active;
      logic [MODE_W-1:0] v_fp;
      logic [MODE_W-1:0] v_sync;
      logic [MODE_W-1:0] v_bp;
      logic              h_neg;
      logic              v_neg;
   } vga_mode_t;

   // Thresholds: *_act first blanked count, *_ss first sync count,
   // *_se first count past sync, *_last final count of the line/frame.
   typedef struct packed {
      logic [MODE_W-1:0] h_act;
      logic [MODE_W-1:0] h_ss;
      logic [MODE_W-1:0] h_se;
      logic [MODE_W-1:0] h_last;
      logic [MODE_W-1:0] v_act;
      logic [MODE_W-1:0] v_ss;
      logic [MODE_W-1:0] v_se;
      logic [MODE_W-1:0] v_last;
      logic              h_neg;
      logic              v_neg;
   } vga_lim_t;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } mode_state_e;

   localparam vga_mode_t MODE_XGA_TIMING = '{
      h_active: MODE_W'(1024), h_fp: MODE_W'(24), h_sync: MODE_W'(136), h_bp: MODE_W'(160),
      v_active: MODE_W'(768),  v_fp: MODE_W'(3),  v_sync: MODE_W'(6),   v_bp: MODE_W'(29),
      h_neg: 1'b1, v_neg: 1'b1
   };

   localparam vga_mode_t MODE_SVGA_TIMING = '{
      h_active: MODE_W'(800), h_fp: MODE_W'(40), h_sync: MODE_W'(128), h_bp: MODE_W'(88),
      v_active: MODE_W'(600), v_fp: MODE_W'(1),  v_sync: MODE_W'(4),   v_bp: MODE_W'(23),
      h_neg: 1'b0, v_neg: 1'b0
   };

   localparam vga_mode_t [NUM_MODES-1:0] VGA_MODES = {MODE_SVGA_TIMING, MODE_XGA_TIMING};

   function automatic logic [MODE_W-1:0] h_total(input vga_mode_t m);
      return m.h_active + m.h_fp + m.h_sync + m.h_bp;
   endfunction

   function automatic logic [MODE_W-1:0] v_total(input vga_mode_t m);
      return m.v_active + m.v_fp + m.v_sync + m.v_bp;
   endfunction

   function automatic vga_lim_t mode_limits(input vga_mode_t m);
      vga_lim_t l;
      l.h_act  = m.h_active;
      l.h_ss   = m.h_active + m.h_fp;
      l.h_se   = m.h_active + m.h_fp + m.h_sync;
      l.h_last = h_total(m) - MODE_W'(1);
      l.v_act  = m.v_active;
      l.v_ss   = m.v_active + m.v_fp;
      l.v_se   = m.v_active + m.v_fp + m.v_sync;
      l.v_last = v_total(m) - MODE_W'(1);
      l.h_neg  = m.h_neg;
      l.v_neg  = m.v_neg;
      return l;
   endfunction

endpackage

// File: rtl/itf_vga_no_rgb.sv
// Raster timing bundle without pixel data, driven by the timing generator
// into the background/draw stages.
//   hcount, vcount  current pixel position
//   hsync, vsync    sync levels (polarity already applied)
//   hblnk, vblnk    outside the active area
interface itf_vga_no_rgb #(
   parameter int unsigned CNT_W = 11
);
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             hsync;
   logic             vsync;
   logic             hblnk;
   logic             vblnk;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_mode_ctrl.sv
// Mode-switch handshake: latches a requested mode and applies it on the
// end-of-frame strobe from the counter core.
//   clk, rst        pixel clock, synchronous active-high reset
//   mode_req/sel    request and requested mode index
//   frame_end_c     presented pixel is the last one of the frame
//   cur_mode        mode of the presented pixel (registered)
//   mode_busy       request latched, not yet applied (registered)
//   mode_ack        first pixel of the new mode is presented (registered)
//   nxt_mode_c      mode of the pixel presented after the next edge
module vga_mode_ctrl
   import DH_pkg::*;
#(
   parameter logic RST_MODE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic mode_req,
   input  logic mode_sel,
   input  logic frame_end_c,
   output logic cur_mode,
   output logic mode_busy,
   output logic mode_ack,
   output logic nxt_mode_c
);

   mode_state_e state_q, state_n;
   logic        pend_sel_q, pend_sel_n;
   logic        busy_n, ack_n;

   // State and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pend_sel_q <= RST_MODE;
         cur_mode   <= RST_MODE;
         mode_busy  <= 1'b0;
         mode_ack   <= 1'b0;
      end else begin
         state_q    <= state_n;
         pend_sel_q <= pend_sel_n;
         cur_mode   <= nxt_mode_c;
         mode_busy  <= busy_n;
         mode_ack   <= ack_n;
      end
   end

   // Next state; a request while pending is dropped (first request wins).
   always_comb begin
      state_n    = state_q;
      pend_sel_n = pend_sel_q;
      nxt_mode_c = cur_mode;
      busy_n     = 1'b0;
      ack_n      = 1'b0;
      case (state_q)
         IDLE: begin
            if (mode_req) begin
               state_n    = PENDING;
               pend_sel_n = mode_sel;
               busy_n     = 1'b1;
            end
         end
         PENDING: begin
            busy_n = 1'b1;
            if (frame_end_c) begin
               state_n    = IDLE;
               nxt_mode_c = pend_sel_q;
               busy_n     = 1'b0;
               ack_n      = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Multi-mode VGA timing generator: pixel/line counters, sync and blanking
// for one of the modes in MODE_TAB, with frame-aligned mode switching.
//   clk, rst              pixel clock, synchronous active-high reset
//   mode_req, mode_sel    switch request / requested mode index
//   mode_busy, mode_ack   handshake status, ack pulses on first new pixel
//   cur_mode              mode of the presented pixel
//   out                   hcount, vcount, hsync, vsync, hblnk, vblnk
//   new_frame, new_line   presented pixel is (0,0) / hcount is 0
//   frame_cnt             frames since reset, only with VGA_TIMING_FRAME_CNT_EN
// Counters and strobes are all decoded from the next pixel and registered
// together, so every output describes the same presented pixel.
module vga_timing_gen
   import DH_pkg::*;
#(
   parameter int unsigned               RST_MODE = 0,
   parameter int unsigned               CNT_W    = 11,
   parameter vga_mode_t [NUM_MODES-1:0] MODE_TAB = VGA_MODES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_req,
   input  logic             mode_sel,
   output logic             mode_busy,
   output logic             mode_ack,
   output logic             cur_mode,
   itf_vga_no_rgb.out       out,
   output logic             new_frame,
   output logic             new_line
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [FRAME_W-1:0] frame_cnt
`endif
);

   localparam vga_lim_t LIM0    = mode_limits(MODE_TAB[0]);
   localparam vga_lim_t LIM1    = mode_limits(MODE_TAB[1]);
   localparam logic     RST_SEL = 1'(RST_MODE);
   localparam logic     RST_HS  = RST_SEL ? LIM1.h_neg : LIM0.h_neg;
   localparam logic     RST_VS  = RST_SEL ? LIM1.v_neg : LIM0.v_neg;

   logic             running_q;
   logic [CNT_W-1:0] hcount_q, vcount_q;
   logic [CNT_W-1:0] hcount_n, vcount_n;
   logic             hsync_q, vsync_q, hblnk_q, vblnk_q;
   logic             hsync_n, vsync_n, hblnk_n, vblnk_n;
   logic             new_frame_n, new_line_n;
   logic             frame_end_c, nxt_mode_c;

   logic [CNT_W-1:0] cur_h_last_c, cur_v_last_c;
   logic [CNT_W-1:0] nxt_h_act_c, nxt_h_ss_c, nxt_h_se_c;
   logic [CNT_W-1:0] nxt_v_act_c, nxt_v_ss_c, nxt_v_se_c;
   logic             nxt_h_neg_c, nxt_v_neg_c;

   vga_mode_ctrl #(
      .RST_MODE (RST_SEL)
   ) u_mode_ctrl (
      .clk         (clk),
      .rst         (rst),
      .mode_req    (mode_req),
      .mode_sel    (mode_sel),
      .frame_end_c (frame_end_c),
      .cur_mode    (cur_mode),
      .mode_busy   (mode_busy),
      .mode_ack    (mode_ack),
      .nxt_mode_c  (nxt_mode_c)
   );

   // Wrap limits of the presented mode.
   assign cur_h_last_c = cur_mode ? CNT_W'(LIM1.h_last) : CNT_W'(LIM0.h_last);
   assign cur_v_last_c = cur_mode ? CNT_W'(LIM1.v_last) : CNT_W'(LIM0.v_last);

   // Decode limits of the mode the next pixel belongs to (differs at a switch).
   assign nxt_h_act_c = nxt_mode_c ? CNT_W'(LIM1.h_act) : CNT_W'(LIM0.h_act);
   assign nxt_h_ss_c  = nxt_mode_c ? CNT_W'(LIM1.h_ss)  : CNT_W'(LIM0.h_ss);
   assign nxt_h_se_c  = nxt_mode_c ? CNT_W'(LIM1.h_se)  : CNT_W'(LIM0.h_se);
   assign nxt_v_act_c = nxt_mode_c ? CNT_W'(LIM1.v_act) : CNT_W'(LIM0.v_act);
   assign nxt_v_ss_c  = nxt_mode_c ? CNT_W'(LIM1.v_ss)  : CNT_W'(LIM0.v_ss);
   assign nxt_v_se_c  = nxt_mode_c ? CNT_W'(LIM1.v_se)  : CNT_W'(LIM0.v_se);
   assign nxt_h_neg_c = nxt_mode_c ? LIM1.h_neg : LIM0.h_neg;
   assign nxt_v_neg_c = nxt_mode_c ? LIM1.v_neg : LIM0.v_neg;

   // Next pixel position; the first cycle after reset presents (0,0).
   always_comb begin
      frame_end_c = running_q && (hcount_q == cur_h_last_c) && (vcount_q == cur_v_last_c);
      hcount_n    = '0;
      vcount_n    = '0;
      if (running_q) begin
         if (hcount_q == cur_h_last_c) begin
            hcount_n = '0;
            vcount_n = (vcount_q == cur_v_last_c) ? '0 : vcount_q + CNT_W'(1);
         end else begin
            hcount_n = hcount_q + CNT_W'(1);
            vcount_n = vcount_q;
         end
      end
   end

   // Strobes for the next pixel, in the next pixel's mode.
   always_comb begin
      hblnk_n     = (hcount_n >= nxt_h_act_c);
      vblnk_n     = (vcount_n >= nxt_v_act_c);
      hsync_n     = ((hcount_n >= nxt_h_ss_c) && (hcount_n < nxt_h_se_c)) ^ nxt_h_neg_c;
      vsync_n     = ((vcount_n >= nxt_v_ss_c) && (vcount_n < nxt_v_se_c)) ^ nxt_v_neg_c;
      new_line_n  = (hcount_n == '0);
      new_frame_n = (hcount_n == '0) && (vcount_n == '0);
   end

   // Presented pixel registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         running_q <= 1'b0;
         hcount_q  <= '0;
         vcount_q  <= '0;
         hblnk_q   <= 1'b0;
         vblnk_q   <= 1'b0;
         hsync_q   <= RST_HS;
         vsync_q   <= RST_VS;
         new_frame <= 1'b0;
         new_line  <= 1'b0;
      end else begin
         running_q <= 1'b1;
         hcount_q  <= hcount_n;
         vcount_q  <= vcount_n;
         hblnk_q   <= hblnk_n;
         vblnk_q   <= vblnk_n;
         hsync_q   <= hsync_n;
         vsync_q   <= vsync_n;
         new_frame <= new_frame_n;
         new_line  <= new_line_n;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   // Frame counter, advanced together with the presented new_frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (new_frame_n) begin
         frame_cnt <= frame_cnt + FRAME_W'(1);
      end
   end
`endif

   assign out.hcount = hcount_q;
   assign out.vcount = vcount_q;
   assign out.hsync  = hsync_q;
   assign out.vsync  = vsync_q;
   assign out.hblnk  = hblnk_q;
   assign out.vblnk  = vblnk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Three instances share clock and reset:
//   u_dut_a  shrunken two-mode table, RST_MODE 0, random switch traffic
//   u_dut_b  real VESA table, RST_MODE 0, free running (first lines)
//   u_dut_c  real VESA table, RST_MODE 1, free running (first lines)
// A reference model tracks each instance as a linear pixel index inside the
// current frame and derives position/strobes by division and modulo.
module tb_vga_timing_gen;
   import DH_pkg::*;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb;
      bit hneg, vneg;
   } tm_t;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs, vs, hb, vb, nf, nl, ack, busy, mode;
      logic [15:0] fc;
   } exp_t;

   localparam vga_mode_t S0 = '{
      h_active: 11'd16, h_fp: 11'd2, h_sync: 11'd3, h_bp: 11'd4,
      v_active: 11'd6,  v_fp: 11'd1, v_sync: 11'd2, v_bp: 11'd2,
      h_neg: 1'b1, v_neg: 1'b1};
   localparam vga_mode_t S1 = '{
      h_active: 11'd12, h_fp: 11'd1, h_sync: 11'd2, h_bp: 11'd3,
      v_active: 11'd5,  v_fp: 11'd1, v_sync: 11'd1, v_bp: 11'd2,
      h_neg: 1'b0, v_neg: 1'b0};

   logic clk, rst, req_a, sel_a;
   logic zero;
   logic busy_a, ack_a, mode_a, nf_a, nl_a;
   logic busy_b, ack_b, mode_b, nf_b, nl_b;
   logic busy_c, ack_c, mode_c, nf_c, nl_c;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] fc_a, fc_b, fc_c;
`endif

   itf_vga_no_rgb #(.CNT_W(11)) vga_a ();
   itf_vga_no_rgb #(.CNT_W(11)) vga_b ();
   itf_vga_no_rgb #(.CNT_W(11)) vga_c ();

   vga_timing_gen #(.RST_MODE(0), .CNT_W(11), .MODE_TAB({S1, S0})) u_dut_a (
      .clk(clk), .rst(rst), .mode_req(req_a), .mode_sel(sel_a),
      .mode_busy(busy_a), .mode_ack(ack_a), .cur_mode(mode_a), .out(vga_a),
      .new_frame(nf_a), .new_line(nl_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc_a)
`endif
   );

   vga_timing_gen #(.RST_MODE(0), .CNT_W(11)) u_dut_b (
      .clk(clk), .rst(rst), .mode_req(zero), .mode_sel(zero),
      .mode_busy(busy_b), .mode_ack(ack_b), .cur_mode(mode_b), .out(vga_b),
      .new_frame(nf_b), .new_line(nl_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc_b)
`endif
   );

   vga_timing_gen #(.RST_MODE(1), .CNT_W(11)) u_dut_c (
      .clk(clk), .rst(rst), .mode_req(zero), .mode_sel(zero),
      .mode_busy(busy_c), .mode_ack(ack_c), .cur_mode(mode_c), .out(vga_c),
      .new_frame(nf_c), .new_line(nl_c)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc_c)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   tm_t         tab [3][2];
   int          rstm [3];
   bit          m_started [3];
   bit          m_pend [3];
   int          m_mode [3];
   int          m_psel [3];
   int          m_pix [3];
   logic [15:0] m_fc [3];

   exp_t q0[$], q1[$], q2[$];
   int   vectors = 0;
   int   errors  = 0;
   bit   chk_on  = 1'b0;

   initial begin
      tab[0][0] = '{16, 2, 3, 4, 6, 1, 2, 2, 1'b1, 1'b1};
      tab[0][1] = '{12, 1, 2, 3, 5, 1, 1, 2, 1'b0, 1'b0};
      tab[1][0] = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b1, 1'b1};
      tab[1][1] = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0};
      tab[2][0] = tab[1][0];
      tab[2][1] = tab[1][1];
      rstm[0] = 0;
      rstm[1] = 0;
      rstm[2] = 1;
   end

   function automatic int htot(input int d, input int m);
      return tab[d][m].ha + tab[d][m].hf + tab[d][m].hs + tab[d][m].hb;
   endfunction

   function automatic int vtot(input int d, input int m);
      return tab[d][m].va + tab[d][m].vf + tab[d][m].vs + tab[d][m].vb;
   endfunction

   // Expected outputs after one clock edge with the given inputs.
   function automatic exp_t model_step(input int d, input bit r, input bit req, input bit sel);
      exp_t e;
      tm_t  t;
      int   ht, vt, x, y;
      bit   was_pend;
      e = '0;
      if (r) begin
         m_started[d] = 1'b0;
         m_pend[d]    = 1'b0;
         m_mode[d]    = rstm[d];
         m_pix[d]     = 0;
         m_fc[d]      = 16'd0;
         e.mode = 1'(rstm[d]);
         e.hs   = tab[d][rstm[d]].hneg;
         e.vs   = tab[d][rstm[d]].vneg;
         return e;
      end
      ht = htot(d, m_mode[d]);
      vt = vtot(d, m_mode[d]);
      was_pend = m_pend[d];
      if (!m_started[d]) begin
         m_started[d] = 1'b1;
         m_pix[d]     = 0;
      end else if (was_pend && m_pix[d] == ht * vt - 1) begin
         m_mode[d] = m_psel[d];
         m_pend[d] = 1'b0;
         m_pix[d]  = 0;
         e.ack     = 1'b1;
      end else begin
         m_pix[d] = (m_pix[d] + 1) % (ht * vt);
      end
      if (!was_pend && req) begin
         m_pend[d] = 1'b1;
         m_psel[d] = sel ? 1 : 0;
      end
      t  = tab[d][m_mode[d]];
      ht = htot(d, m_mode[d]);
      x  = m_pix[d] % ht;
      y  = m_pix[d] / ht;
      if (m_pix[d] == 0) m_fc[d] = m_fc[d] + 16'd1;
      e.h    = 11'(x);
      e.v    = 11'(y);
      e.hb   = (x >= t.ha);
      e.vb   = (y >= t.va);
      e.hs   = ((x >= t.ha + t.hf) && (x < t.ha + t.hf + t.hs)) ^ t.hneg;
      e.vs   = ((y >= t.va + t.vf) && (y < t.va + t.vf + t.vs)) ^ t.vneg;
      e.nf   = (m_pix[d] == 0);
      e.nl   = (x == 0);
      e.busy = m_pend[d];
      e.mode = 1'(m_mode[d]);
`ifdef VGA_TIMING_FRAME_CNT_EN
      e.fc   = m_fc[d];
`endif
      return e;
   endfunction

   // Model advances on every active edge using the inputs the DUT samples.
   always @(posedge clk) begin
      q0.push_back(model_step(0, rst, req_a, sel_a));
      q1.push_back(model_step(1, rst, 1'b0, 1'b0));
      q2.push_back(model_step(2, rst, 1'b0, 1'b0));
      chk_on <= 1'b1;
   end

   // ---------------- monitor ----------------
   function automatic exp_t act_a();
      exp_t a;
      a = '0;
      a.h = vga_a.hcount; a.v = vga_a.vcount;
      a.hs = vga_a.hsync; a.vs = vga_a.vsync; a.hb = vga_a.hblnk; a.vb = vga_a.vblnk;
      a.nf = nf_a; a.nl = nl_a; a.ack = ack_a; a.busy = busy_a; a.mode = mode_a;
`ifdef VGA_TIMING_FRAME_CNT_EN
      a.fc = fc_a;
`endif
      return a;
   endfunction

   function automatic exp_t act_b();
      exp_t a;
      a = '0;
      a.h = vga_b.hcount; a.v = vga_b.vcount;
      a.hs = vga_b.hsync; a.vs = vga_b.vsync; a.hb = vga_b.hblnk; a.vb = vga_b.vblnk;
      a.nf = nf_b; a.nl = nl_b; a.ack = ack_b; a.busy = busy_b; a.mode = mode_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
      a.fc = fc_b;
`endif
      return a;
   endfunction

   function automatic exp_t act_c();
      exp_t a;
      a = '0;
      a.h = vga_c.hcount; a.v = vga_c.vcount;
      a.hs = vga_c.hsync; a.vs = vga_c.vsync; a.hb = vga_c.hblnk; a.vb = vga_c.vblnk;
      a.nf = nf_c; a.nl = nl_c; a.ack = ack_c; a.busy = busy_c; a.mode = mode_c;
`ifdef VGA_TIMING_FRAME_CNT_EN
      a.fc = fc_c;
`endif
      return a;
   endfunction

   task automatic check(input int d, input exp_t e, input exp_t a);
      vectors++;
      if (a !== e) begin
         errors++;
         $display("FAIL dut%0d pixel t=%0t: got h=%0d v=%0d {hs,vs,hb,vb,nf,nl,ack,busy,mode}=%b fc=%0d, expected h=%0d v=%0d flags=%b fc=%0d",
                  d, $time, a.h, a.v, {a.hs, a.vs, a.hb, a.vb, a.nf, a.nl, a.ack, a.busy, a.mode}, a.fc,
                  e.h, e.v, {e.hs, e.vs, e.hb, e.vb, e.nf, e.nl, e.ack, e.busy, e.mode}, e.fc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL scoreboard: expected entry missing, sizes %0d/%0d/%0d, required >0",
                     q0.size(), q1.size(), q2.size());
         end else begin
            check(0, q0.pop_front(), act_a());
            check(1, q1.pop_front(), act_b());
            check(2, q2.pop_front(), act_c());
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_req(input bit s);
      req_a = 1'b1;
      sel_a = s;
      @(negedge clk);
      req_a = 1'b0;
   endtask

   // Stops at the negedge where dut A presents the last pixel of its frame.
   task automatic wait_last(output bit found);
      int m;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         m = mode_a ? 1 : 0;
         if (int'(vga_a.hcount) == htot(0, m) - 1 && int'(vga_a.vcount) == vtot(0, m) - 1)
            found = 1'b1;
      end
   endtask

   initial begin
      bit found;
      zero  = 1'b0;
      rst   = 1'b1;
      req_a = 1'b0;
      sel_a = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // two frames of the reset mode
      repeat (2 * 275 + 37) @(negedge clk);
      // mid-frame switch to mode 1; the competing request is ignored
      pulse_req(1'b1);
      repeat (20) @(negedge clk);
      pulse_req(1'b0);
      repeat (275 + 2 * 162) @(negedge clk);
      // request for the mode already running
      pulse_req(1'b1);
      repeat (2 * 162 + 11) @(negedge clk);
      // request on the last pixel: applied one frame later
      wait_last(found);
      vectors++;
      if (!found) begin
         errors++;
         $display("FAIL last_pixel_wait: got no frame end within 600 cycles, required one");
      end
      pulse_req(1'b0);
      repeat (2 * 275 + 200) @(negedge clk);
      // reset while pending
      pulse_req(1'b1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      // random traffic
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(1, 320)) @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
         end else begin
            req_a = 1'b1;
            sel_a = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) @(negedge clk);
            req_a = 1'b0;
         end
      end
      repeat (600) @(negedge clk);
      vectors++;
      if (q0.size() > 1) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries, required at most 1", q0.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
